// File: rtl/byte_frame_collector.sv
// Packs N_BYTES stream bytes into the adder operand bus, waits one settle cycle, then registers the sum.
// Optional early frame close via in_last when COLLECT_LAST_EN is defined.
module byte_frame_collector #(
    parameter int N_BYTES = 10,
    parameter int W       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_data,
`ifdef COLLECT_LAST_EN
    input  logic                 in_last,
`endif
    output logic [N_BYTES*W-1:0] frame_data,
    input  logic [12:0]          sum_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [12:0]          out_sum,
    output logic [3:0]           out_count,
    output logic [1:0]           state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // a source holds valid and its payload stable until that edge, ready never depends on valid.

    typedef enum logic [1:0] {
        FILL = 2'd0,
        SUM  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] idx;
    logic       accept;
    logic       last_byte;
    logic       close_frame;

    assign in_ready  = (state == FILL);
    assign accept    = in_valid && in_ready;
    assign state_dbg = state;

`ifdef COLLECT_LAST_EN
    assign last_byte = in_last;
`else
    assign last_byte = 1'b0;
`endif

    assign close_frame = accept && ((idx == 4'(N_BYTES - 1)) || last_byte);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            idx        <= 4'd0;
            frame_data <= '0;
            out_sum    <= 13'd0;
            out_count  <= 4'd0;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        for (int k = 0; k < N_BYTES; k++) begin
                            if (idx == 4'(k)) begin
                                frame_data[k*W +: W] <= in_data;
                            end
                        end
                        // idx doubles as the accepted-byte count once the frame closes
                        idx <= idx + 4'd1;
                        if (close_frame) begin
                            state <= SUM;
                        end
                    end
                end
                SUM: begin
                    out_sum   <= sum_in;
                    out_count <= idx;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_valid && out_ready) begin
                        out_valid  <= 1'b0;
                        frame_data <= '0;
                        idx        <= 4'd0;
                        state      <= FILL;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_frame_collector.sv
// Directed bench for byte_frame_collector; models the combinational adder and checks results in order.
// Build with +define+COLLECT_LAST_EN to exercise early frame close.
module tb_byte_frame_collector;

    localparam int N_BYTES = 10;
    localparam int W       = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [W-1:0]         in_data;
    logic                 in_last;
    logic [N_BYTES*W-1:0] frame_data;
    logic [12:0]          sum_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [12:0]          out_sum;
    logic [3:0]           out_count;
    logic [1:0]           state_dbg;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [16:0] exp_q[$];
    logic [16:0] got_q[$];
    logic        prev_valid = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    byte_frame_collector #(.N_BYTES(N_BYTES), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef COLLECT_LAST_EN
        .in_last   (in_last),
`endif
        .frame_data(frame_data),
        .sum_in    (sum_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .state_dbg (state_dbg)
    );

    // Adder tree model: plain sum of the ten operand slots
    always_comb begin
        sum_in = 13'd0;
        for (int k = 0; k < N_BYTES; k++) sum_in = sum_in + 13'(frame_data[k*W +: W]);
    end

    // Capture each result once, when out_valid rises
    always @(negedge clk) begin
        if (out_valid && !prev_valid) got_q.push_back({out_count, out_sum});
        prev_valid <= out_valid;
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge
    task automatic send_byte(input logic [7:0] d, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 80'(n), 80'(0));
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    int t_a, t_b;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        check("rst_out_valid", 80'(out_valid), 80'(0));
        check("rst_out_sum", 80'(out_sum), 80'(0));
        check("rst_out_count", 80'(out_count), 80'(0));
        check("rst_frame_data", 80'(frame_data), 80'(0));
        check("rst_in_ready", 80'(in_ready), 80'(1));
        rst_n = 1'b1;
        @(negedge clk);

        // Contiguous frame 1..10
        for (int i = 1; i <= 10; i++) send_byte(8'(i), 1'b0);
        check("contig_valid_e0", 80'(out_valid), 80'(0));
        check("contig_slot0", 80'(frame_data[7:0]), 80'(1));
        check("contig_slot9", 80'(frame_data[79:72]), 80'(10));
        @(negedge clk);
        check("contig_valid_e1", 80'(out_valid), 80'(1));
        check("contig_sum", 80'(out_sum), 80'(55));
        check("contig_count", 80'(out_count), 80'(10));
        exp_q.push_back({4'd10, 13'd55});
        @(negedge clk);
        check("contig_valid_one_cycle", 80'(out_valid), 80'(0));
        check("contig_in_ready_back", 80'(in_ready), 80'(1));

        // Gapped 0xFF frame with backpressure
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send_byte(8'hFF, 1'b0);
            if (i < 9) @(negedge clk);
        end
        check("bp_in_ready_sum", 80'(in_ready), 80'(0));
        @(negedge clk);
        exp_q.push_back({4'd10, 13'd2550});
        in_valid = 1'b1;
        in_data  = 8'h77;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid_held", 80'(out_valid), 80'(1));
            check("bp_sum_held", 80'(out_sum), 80'(2550));
            check("bp_in_ready_low", 80'(in_ready), 80'(0));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_after_hs_valid", 80'(out_valid), 80'(0));
        check("bp_after_hs_ready", 80'(in_ready), 80'(1));
        check("bp_extra_not_taken", 80'(frame_data), 80'(0));
        @(negedge clk);
        check("bp_extra_taken", 80'(frame_data[7:0]), 80'(8'h77));
        for (int i = 0; i < 3; i++) send_byte(8'h50, 1'b0);

        // Abort the 4-byte partial frame with reset
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 80'(out_valid), 80'(0));
        check("midrst_frame_data", 80'(frame_data), 80'(0));
        check("midrst_out_sum", 80'(out_sum), 80'(0));
        check("midrst_out_count", 80'(out_count), 80'(0));
        check("midrst_in_ready", 80'(in_ready), 80'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) send_byte(8'h03, 1'b0);
        @(negedge clk);
        check("midrst_sum", 80'(out_sum), 80'(30));
        exp_q.push_back({4'd10, 13'd30});
        @(negedge clk);

        // Back-to-back frames: 0xFF x10 then 0x01 x10
        for (int i = 0; i < 10; i++) send_byte(8'hFF, 1'b0);
        t_a = cyc;
        exp_q.push_back({4'd10, 13'd2550});
        for (int i = 0; i < 10; i++) send_byte(8'h01, 1'b0);
        t_b = cyc;
        exp_q.push_back({4'd10, 13'd10});
        check("b2b_period", 80'(t_b - t_a), 80'(12));
        @(negedge clk);
        check("b2b_sum2", 80'(out_sum), 80'(10));
        @(negedge clk);

`ifdef COLLECT_LAST_EN
        send_byte(8'd5, 1'b0);
        send_byte(8'd6, 1'b0);
        send_byte(8'd7, 1'b1);
        check("last_upper_zero", 80'(frame_data[79:24]), 80'(0));
        @(negedge clk);
        check("last_sum", 80'(out_sum), 80'(18));
        check("last_count", 80'(out_count), 80'(3));
        exp_q.push_back({4'd3, 13'd18});
        @(negedge clk);
`else
        send_byte(8'd5, 1'b0);
        send_byte(8'd6, 1'b0);
        send_byte(8'd7, 1'b1);
        repeat (4) @(negedge clk);
        check("nolast_no_result", 80'(out_valid), 80'(0));
        check("nolast_still_fill", 80'(in_ready), 80'(1));
        for (int i = 0; i < 7; i++) send_byte(8'd0, 1'b0);
        @(negedge clk);
        check("nolast_sum", 80'(out_sum), 80'(18));
        check("nolast_count", 80'(out_count), 80'(10));
        exp_q.push_back({4'd10, 13'd18});
        @(negedge clk);
`endif

        // Scoreboard: every result in order, and no stray result from the aborted frame
        repeat (3) @(negedge clk);
        check("result_count", 80'(got_q.size()), 80'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            check("result_seq", 80'(got_q.pop_front()), 80'(exp_q.pop_front()));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
